// File: rtl/multi_player_mover_pkg.sv
// Shared arena geometry and position types for the sprite movers.
// No logic; constants and types only.
// No backpressure.
package multi_player_mover_pkg;

    localparam int POS_W      = 10;
    localparam int X_MIN      = 0;
    localparam int X_MAX      = 639;
    localparam int Y_MIN      = 0;
    localparam int Y_MAX      = 479;
    localparam int RADIUS_DEF = 25;

    typedef logic [POS_W-1:0] pos_t;

    // One player's synchronised button set.
    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } btn_t;

endpackage

// File: rtl/multi_player_mover_if.sv
// Button inputs and packed sprite positions between game logic and the mover.
// No latency of its own; bundle of wires only.
// No backpressure: positions are levels, move_tick is a single-cycle pulse.
// Ports: game_on, btn_up/down/left/right (one bit per player) in;
//        pos_x, pos_y (player i at [i*POS_W +: POS_W]), moving, move_tick out.
interface multi_player_mover_if
    import multi_player_mover_pkg::*;
#(
    parameter int NUM_PLAYERS = 2
);
    logic                         game_on;
    logic [NUM_PLAYERS-1:0]       btn_up;
    logic [NUM_PLAYERS-1:0]       btn_down;
    logic [NUM_PLAYERS-1:0]       btn_left;
    logic [NUM_PLAYERS-1:0]       btn_right;
    logic [NUM_PLAYERS*POS_W-1:0] pos_x;
    logic [NUM_PLAYERS*POS_W-1:0] pos_y;
    logic [NUM_PLAYERS-1:0]       moving;
    logic                         move_tick;

    modport master (
        output game_on, btn_up, btn_down, btn_left, btn_right,
        input  pos_x, pos_y, moving, move_tick
    );

    modport slave (
        input  game_on, btn_up, btn_down, btn_left, btn_right,
        output pos_x, pos_y, moving, move_tick
    );
endinterface

// File: rtl/multi_player_mover_axis.sv
// One axis of one player: steps a position toward dir_pos/dir_neg, clamped so the sprite stays inside.
// Purely combinational.
// No backpressure.
// Ports: dir_pos/dir_neg (direction requests), step, pos in; pos_nxt, changed out.
module multi_player_mover_axis
    import multi_player_mover_pkg::*;
#(
    parameter int MIN    = 0,
    parameter int MAX    = 639,
    parameter int RADIUS = 25
) (
    input  logic dir_pos,
    input  logic dir_neg,
    input  pos_t step,
    input  pos_t pos,
    output pos_t pos_nxt,
    output logic changed
);
    localparam logic [POS_W:0] HI = (POS_W+1)'(MAX - RADIUS);
    localparam logic [POS_W:0] LO = (POS_W+1)'(MIN + RADIUS);

    // Extra bit keeps the sum and the lower limit free of wrap-around.
    logic [POS_W:0] sum;
    logic [POS_W:0] lo_lim;

    always_comb begin
        sum     = {1'b0, pos} + {1'b0, step};
        lo_lim  = LO + {1'b0, step};
        pos_nxt = pos;
        if (dir_pos && !dir_neg) begin
            pos_nxt = (sum > HI) ? HI[POS_W-1:0] : sum[POS_W-1:0];
        end else if (dir_neg && !dir_pos) begin
            pos_nxt = ({1'b0, pos} < lo_lim) ? LO[POS_W-1:0] : pos - step;
        end
        changed = (pos_nxt != pos);
    end
endmodule

// File: rtl/multi_player_mover.sv
// Moves NUM_PLAYERS sprites from buttons on a programmable tick, clamped to the arena, with hold-to-accelerate.
// Buttons visible 2 cycles after input; positions/moving/move_tick update on the tick edge.
// No backpressure; game_on=0 freezes the tick counter and all movement state.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries game_on, buttons, positions, moving, move_tick.
module multi_player_mover
    import multi_player_mover_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int MOVE_PERIOD = 200000,
    parameter int STEP        = 1,
    parameter int FAST_STEP   = 3,
    parameter int ACCEL_TICKS = 16,
    parameter int RADIUS      = RADIUS_DEF,
    parameter logic [NUM_PLAYERS*POS_W-1:0] INIT_X = {10'd410, 10'd230},
    parameter logic [NUM_PLAYERS*POS_W-1:0] INIT_Y = {10'd250, 10'd250}
) (
    input logic                clk,
    input logic                rst,
    multi_player_mover_if.slave bus
);
    localparam int CNT_W  = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);

    logic [CNT_W-1:0]       cnt;
    logic                   tick;
    btn_t [NUM_PLAYERS-1:0] sync1;
    btn_t [NUM_PLAYERS-1:0] sync2;
    pos_t                   px     [NUM_PLAYERS];
    pos_t                   py     [NUM_PLAYERS];
    pos_t                   nx     [NUM_PLAYERS];
    pos_t                   ny     [NUM_PLAYERS];
    logic                   cx     [NUM_PLAYERS];
    logic                   cy     [NUM_PLAYERS];
    pos_t                   step_w [NUM_PLAYERS];
    logic                   active [NUM_PLAYERS];
    logic [HOLD_W-1:0]      hold   [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] moving_q;
    logic                   move_tick_q;

    assign tick = bus.game_on && (cnt == CNT_W'(MOVE_PERIOD - 1));

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
        // Opposing buttons cancel, so only a lone button counts as holding.
        assign active[g] = (sync2[g].up ^ sync2[g].down) | (sync2[g].left ^ sync2[g].right);
        assign step_w[g] = (hold[g] == HOLD_W'(ACCEL_TICKS)) ? POS_W'(FAST_STEP) : POS_W'(STEP);

        multi_player_mover_axis #(.MIN(X_MIN), .MAX(X_MAX), .RADIUS(RADIUS)) u_x (
            .dir_pos (sync2[g].right),
            .dir_neg (sync2[g].left),
            .step    (step_w[g]),
            .pos     (px[g]),
            .pos_nxt (nx[g]),
            .changed (cx[g])
        );

        // Screen coordinates: up decreases Y.
        multi_player_mover_axis #(.MIN(Y_MIN), .MAX(Y_MAX), .RADIUS(RADIUS)) u_y (
            .dir_pos (sync2[g].down),
            .dir_neg (sync2[g].up),
            .step    (step_w[g]),
            .pos     (py[g]),
            .pos_nxt (ny[g]),
            .changed (cy[g])
        );

        assign bus.pos_x[g*POS_W +: POS_W] = px[g];
        assign bus.pos_y[g*POS_W +: POS_W] = py[g];
    end

    assign bus.moving    = moving_q;
    assign bus.move_tick = move_tick_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            sync1       <= '0;
            sync2       <= '0;
            moving_q    <= '0;
            move_tick_q <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                px[i]   <= INIT_X[i*POS_W +: POS_W];
                py[i]   <= INIT_Y[i*POS_W +: POS_W];
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                sync1[i] <= '{up: bus.btn_up[i], down: bus.btn_down[i],
                              left: bus.btn_left[i], right: bus.btn_right[i]};
            end
            sync2       <= sync1;
            move_tick_q <= tick;
            // Pause holds the count so the period resumes where it left off.
            if (bus.game_on) begin
                cnt <= tick ? '0 : cnt + CNT_W'(1);
            end
            if (tick) begin
                for (int i = 0; i < NUM_PLAYERS; i++) begin
                    px[i]       <= nx[i];
                    py[i]       <= ny[i];
                    moving_q[i] <= cx[i] | cy[i];
                    if (!active[i]) begin
                        hold[i] <= '0;
                    end else if (hold[i] != HOLD_W'(ACCEL_TICKS)) begin
                        hold[i] <= hold[i] + HOLD_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_player_mover.sv
// Directed bench for multi_player_mover with a 4-cycle tick and fast acceleration.
// Inputs driven and outputs sampled on the falling edge.
// No backpressure in the design under test.
module tb_multi_player_mover;
    import multi_player_mover_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n;
    int   saw;

    always #5 clk = ~clk;

    multi_player_mover_if #(.NUM_PLAYERS(2)) bus ();

    multi_player_mover #(
        .NUM_PLAYERS (2),
        .MOVE_PERIOD (4),
        .STEP        (1),
        .FAST_STEP   (3),
        .ACCEL_TICKS (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge where move_tick is high; n = falling edges taken.
    task automatic run_to_tick(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.move_tick && cycles < 16);
        check("tick_seen", 32'(bus.move_tick), 1);
    endtask

    initial begin
        rst           = 1'b1;
        bus.game_on   = 1'b1;
        bus.btn_up    = 2'b11;
        bus.btn_down  = 2'b00;
        bus.btn_left  = 2'b00;
        bus.btn_right = 2'b11;
        @(negedge clk);

        // Reset with buttons held
        check("rst_x0", 32'(bus.pos_x[9:0]), 230);
        check("rst_x1", 32'(bus.pos_x[19:10]), 410);
        check("rst_y0", 32'(bus.pos_y[9:0]), 250);
        check("rst_y1", 32'(bus.pos_y[19:10]), 250);
        check("rst_moving", 32'(bus.moving), 0);
        check("rst_tick", 32'(bus.move_tick), 0);

        // Basic move with acceleration
        rst           = 1'b0;
        bus.btn_up    = 2'b00;
        bus.btn_right = 2'b01;
        run_to_tick(n);
        check("first_tick_latency", 32'(n), 4);
        check("mv1_x0", 32'(bus.pos_x[9:0]), 231);
        check("mv1_x1", 32'(bus.pos_x[19:10]), 410);
        check("mv1_y0", 32'(bus.pos_y[9:0]), 250);
        check("mv1_moving", 32'(bus.moving), 2'b01);
        @(negedge clk);
        check("tick_pulse_1cyc", 32'(bus.move_tick), 0);
        run_to_tick(n);
        check("mv2_x0", 32'(bus.pos_x[9:0]), 232);
        run_to_tick(n);
        check("mv3_accel_x0", 32'(bus.pos_x[9:0]), 235);
        bus.btn_right = 2'b00;
        run_to_tick(n);
        check("rel_x0", 32'(bus.pos_x[9:0]), 235);
        check("rel_moving", 32'(bus.moving), 0);
        bus.btn_right = 2'b01;
        run_to_tick(n);
        check("repress_slow_x0", 32'(bus.pos_x[9:0]), 236);
        check("repress_moving", 32'(bus.moving), 2'b01);
        bus.btn_right = 2'b00;
        run_to_tick(n);
        check("idle_moving", 32'(bus.moving), 0);

        // Wall clamps: p0 up to Y_MIN+R, p1 right to X_MAX-R
        bus.btn_up    = 2'b01;
        bus.btn_right = 2'b10;
        for (int k = 1; k <= 78; k++) begin
            run_to_tick(n);
            if (k == 2) begin
                check("wall_y0_k2", 32'(bus.pos_y[9:0]), 248);
                check("wall_x1_k2", 32'(bus.pos_x[19:10]), 412);
            end
            if (k == 69) check("wall_x1_613", 32'(bus.pos_x[19:10]), 613);
            if (k == 70) begin
                check("wall_x1_clamp", 32'(bus.pos_x[19:10]), 614);
                check("wall_mv_k70", 32'(bus.moving), 2'b11);
            end
            if (k == 71) begin
                check("wall_x1_stay", 32'(bus.pos_x[19:10]), 614);
                check("wall_mv_k71", 32'(bus.moving), 2'b01);
            end
            if (k == 75) check("wall_y0_29", 32'(bus.pos_y[9:0]), 29);
            if (k == 76) check("wall_y0_26", 32'(bus.pos_y[9:0]), 26);
            if (k == 77) begin
                check("wall_y0_clamp", 32'(bus.pos_y[9:0]), 25);
                check("wall_mv_k77", 32'(bus.moving), 2'b01);
            end
            if (k == 78) begin
                check("wall_y0_stay", 32'(bus.pos_y[9:0]), 25);
                check("wall_mv_k78", 32'(bus.moving), 0);
            end
        end

        // Cancel: left and right together on p1
        bus.btn_up   = 2'b00;
        bus.btn_left = 2'b10;
        for (int c = 0; c < 5; c++) begin
            run_to_tick(n);
            check("cancel_x1", 32'(bus.pos_x[19:10]), 614);
            check("cancel_moving", 32'(bus.moving), 0);
        end
        bus.btn_right = 2'b00;
        run_to_tick(n);
        check("after_cancel_slow_x1", 32'(bus.pos_x[19:10]), 613);
        check("after_cancel_moving", 32'(bus.moving), 2'b10);
        bus.btn_left = 2'b00;

        // Pause at count==2 with a button pressed
        @(negedge clk);
        @(negedge clk);
        bus.game_on   = 1'b0;
        bus.btn_right = 2'b01;
        saw = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.move_tick) saw++;
        end
        check("pause_no_tick", 32'(saw), 0);
        check("pause_x0", 32'(bus.pos_x[9:0]), 236);
        check("pause_x1", 32'(bus.pos_x[19:10]), 613);
        check("pause_y0", 32'(bus.pos_y[9:0]), 25);
        check("pause_moving_held", 32'(bus.moving), 2'b10);
        bus.game_on = 1'b1;
        run_to_tick(n);
        check("resume_latency", 32'(n), 2);
        check("resume_x0", 32'(bus.pos_x[9:0]), 237);
        check("resume_moving", 32'(bus.moving), 2'b01);

        // Reset on the would-be tick cycle, button still held
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tick", 32'(bus.move_tick), 0);
        check("midrst_x0", 32'(bus.pos_x[9:0]), 230);
        check("midrst_x1", 32'(bus.pos_x[19:10]), 410);
        check("midrst_y0", 32'(bus.pos_y[9:0]), 250);
        check("midrst_moving", 32'(bus.moving), 0);
        rst = 1'b0;
        run_to_tick(n);
        check("post_rst_latency", 32'(n), 4);
        check("post_rst_x0", 32'(bus.pos_x[9:0]), 231);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
